// File: rtl/axis_pkt_pkg.sv
// Shared types and helpers for the AXI4-Stream packet player and its loopback checker.
package axis_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Default stream geometry; the modules take these as their parameter defaults.
  localparam int unsigned PKT_DATA_W = 64;
  localparam int unsigned PKT_KEEP_W = PKT_DATA_W / 8;

  // One stored image beat at the default geometry.
  typedef struct packed {
    logic [PKT_DATA_W-1:0] data;
    logic [PKT_KEEP_W-1:0] keep;
    logic                  last;
  } pkt_beat_t;

  // The final image beat always closes a packet, whatever its stored last bit says.
  function automatic logic eff_last(input logic        stored_last,
                                    input logic [31:0] idx,
                                    input logic [31:0] num_beats);
    return stored_last | (idx == (num_beats - 32'd1));
  endfunction

endpackage

// File: rtl/axis_pkt_checker.sv
// Loopback checker: compares returned S_AXIS beats against the stored image and keeps counters.
module axis_pkt_checker
  import axis_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_W     = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic [ADDR_W:0]       num_beats_i,
  output logic [ADDR_W-1:0]     rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic [KEEP_WIDTH-1:0] rd_keep_i,
  input  logic                  rd_last_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic [KEEP_WIDTH-1:0] s_tkeep_i,
  input  logic                  s_tlast_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  output logic [CNT_W-1:0]      beats_o,
  output logic [CNT_W-1:0]      pkts_o,
  output logic [CNT_W-1:0]      errors_o
);

  logic [ADDR_W-1:0] exp_ptr_q;
  logic [CNT_W-1:0]  beats_q;
  logic [CNT_W-1:0]  pkts_q;
  logic [CNT_W-1:0]  errors_q;
  logic              tready_q;

  logic              hs_s;
  logic              exp_last_s;
  logic              data_bad_s;
  logic              mismatch_s;
  logic              ptr_end_s;

  // Compare the returned beat against the expected image entry (data only on kept bytes).
  always_comb begin
    hs_s       = s_tvalid_i & tready_q;
    exp_last_s = eff_last(rd_last_i, 32'(exp_ptr_q), 32'(num_beats_i));
    data_bad_s = 1'b0;
    for (int b = 0; b < KEEP_WIDTH; b++) begin
      data_bad_s = data_bad_s |
                   (rd_keep_i[b] & (s_tdata_i[8*b +: 8] != rd_data_i[8*b +: 8]));
    end
    mismatch_s = data_bad_s | (s_tkeep_i != rd_keep_i) | (s_tlast_i != exp_last_s);
    ptr_end_s  = ({1'b0, exp_ptr_q} == (num_beats_i - (ADDR_W+1)'(1)));
  end

  // Checker state: clear on accepted start (wins over a same-cycle beat), else count handshakes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exp_ptr_q <= '0;
      beats_q   <= '0;
      pkts_q    <= '0;
      errors_q  <= '0;
      tready_q  <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      if (clr_i) begin
        exp_ptr_q <= '0;
        beats_q   <= '0;
        pkts_q    <= '0;
        errors_q  <= '0;
      end else if (hs_s) begin
        exp_ptr_q <= ptr_end_s ? '0 : (exp_ptr_q + ADDR_W'(1));
        beats_q   <= beats_q + CNT_W'(1);
        pkts_q    <= s_tlast_i ? (pkts_q + CNT_W'(1)) : pkts_q;
        errors_q  <= (mismatch_s && (errors_q != '1)) ? (errors_q + CNT_W'(1)) : errors_q;
      end
    end
  end

  assign rd_addr_o  = exp_ptr_q;
  assign s_tready_o = tready_q;
  assign beats_o    = beats_q;
  assign pkts_o     = pkts_q;
  assign errors_o   = errors_q;

endmodule

// File: rtl/axis_pkt_player.sv
// AXI4-Stream packet player: replays a stored beat image on M_AXIS for N passes,
// with a loopback checker on S_AXIS comparing against the same image.
module axis_pkt_player
  import axis_pkt_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = 32,
  parameter  int CNT_W      = 16,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  ld_en,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic [KEEP_WIDTH-1:0] ld_keep,
  input  logic                  ld_last,
  input  logic                  start,
  input  logic [ADDR_W:0]       num_beats,
  input  logic [CNT_W-1:0]      num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic [KEEP_WIDTH-1:0] M_AXIS_tkeep,
  output logic                  M_AXIS_tlast,
  output logic                  M_AXIS_tvalid,
  input  logic                  M_AXIS_tready,
  input  logic [DATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic [KEEP_WIDTH-1:0] S_AXIS_tkeep,
  input  logic                  S_AXIS_tlast,
  input  logic                  S_AXIS_tvalid,
  output logic                  S_AXIS_tready,
  output logic [CNT_W-1:0]      chk_beats,
  output logic [CNT_W-1:0]      chk_pkts,
  output logic [CNT_W-1:0]      chk_errors
);

  localparam int NB_W = ADDR_W + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
  } beat_t;

  beat_t             mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [NB_W-1:0]   nb_q, nb_d;
  logic [CNT_W-1:0]  np_q, np_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [KEEP_WIDTH-1:0] keep_q, keep_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q;

  logic              start_ok_s;
  logic              clr_s;
  logic              load_s;
  logic [ADDR_W-1:0] ld_ptr_s;
  logic [NB_W-1:0]   ld_nb_s;
  logic [CNT_W-1:0]  ld_np_s;
  logic [CNT_W-1:0]  ld_pc_s;
  logic              ptr_end_s;
  logic              pass_end_s;
  beat_t             rd_beat_s;
  logic [ADDR_W-1:0] chk_addr_s;
  beat_t             chk_beat_s;

  assign start_ok_s = start && (num_beats != '0) && (num_beats <= NB_W'(DEPTH));

  // Image memory write port; loads are only honoured while idle.
  always_ff @(posedge aclk) begin
    if (ld_en && (state_q == ST_IDLE)) begin
      mem_q[ld_addr] <= {ld_data, ld_keep, ld_last};
    end
  end

  // FSM next state and output-register reload; an accepted start loads beat 0 immediately.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    pass_d   = pass_q;
    nb_d     = nb_q;
    np_d     = np_q;
    data_d   = data_q;
    keep_d   = keep_q;
    last_d   = last_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    clr_s    = 1'b0;
    load_s   = 1'b0;
    ld_ptr_s = rd_ptr_q;
    ld_nb_s  = nb_q;
    ld_np_s  = np_q;
    ld_pc_s  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_s) begin
          clr_s    = 1'b1;
          nb_d     = num_beats;
          np_d     = (num_passes == '0) ? CNT_W'(1) : num_passes;
          load_s   = 1'b1;
          ld_ptr_s = '0;
          ld_nb_s  = num_beats;
          ld_np_s  = np_d;
          ld_pc_s  = '0;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!valid_q || M_AXIS_tready) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (M_AXIS_tready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    rd_beat_s  = mem_q[ld_ptr_s];
    ptr_end_s  = ({1'b0, ld_ptr_s} == (ld_nb_s - NB_W'(1)));
    pass_end_s = ((ld_pc_s + CNT_W'(1)) == ld_np_s);
    if (load_s) begin
      data_d  = rd_beat_s.data;
      keep_d  = rd_beat_s.keep;
      last_d  = eff_last(rd_beat_s.last, 32'(ld_ptr_s), 32'(ld_nb_s));
      valid_d = 1'b1;
      if (ptr_end_s) begin
        rd_ptr_d = '0;
        pass_d   = ld_pc_s + CNT_W'(1);
        state_d  = pass_end_s ? ST_FLUSH : ST_RUN;
      end else begin
        rd_ptr_d = ld_ptr_s + ADDR_W'(1);
        pass_d   = ld_pc_s;
        state_d  = ST_RUN;
      end
    end else begin
      rd_beat_s = rd_beat_s;
    end
  end

  // Player state and output registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      rd_ptr_q <= '0;
      pass_q   <= '0;
      nb_q     <= '0;
      np_q     <= '0;
      data_q   <= '0;
      keep_q   <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      pass_q   <= pass_d;
      nb_q     <= nb_d;
      np_q     <= np_d;
      data_q   <= data_d;
      keep_q   <= keep_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign chk_beat_s = mem_q[chk_addr_s];

  axis_pkt_checker #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .ADDR_W     (ADDR_W),
    .CNT_W      (CNT_W)
  ) u_checker (
    .clk_i       (aclk),
    .rst_i       (areset),
    .clr_i       (clr_s),
    .num_beats_i (nb_d),
    .rd_addr_o   (chk_addr_s),
    .rd_data_i   (chk_beat_s.data),
    .rd_keep_i   (chk_beat_s.keep),
    .rd_last_i   (chk_beat_s.last),
    .s_tdata_i   (S_AXIS_tdata),
    .s_tkeep_i   (S_AXIS_tkeep),
    .s_tlast_i   (S_AXIS_tlast),
    .s_tvalid_i  (S_AXIS_tvalid),
    .s_tready_o  (S_AXIS_tready),
    .beats_o     (chk_beats),
    .pkts_o      (chk_pkts),
    .errors_o    (chk_errors)
  );

  assign M_AXIS_tdata  = data_q;
  assign M_AXIS_tkeep  = keep_q;
  assign M_AXIS_tlast  = last_q;
  assign M_AXIS_tvalid = valid_q;
  assign done          = done_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_axis_pkt_player.sv
// Bench for axis_pkt_player: table of replay scenarios in loopback, scoreboarded beats,
// plus hand sequences for reset mid-run, rejected start and loads while busy.
module tb_axis_pkt_player;

  localparam int DW    = 64;
  localparam int KW    = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int CW    = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [KW-1:0] ld_keep;
  logic          ld_last;
  logic          start;
  logic [AW:0]   num_beats;
  logic [CW-1:0] num_passes;
  logic          busy, done;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast, m_tvalid, m_tready;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast, s_tvalid, s_tready;
  logic [CW-1:0] chk_beats, chk_pkts, chk_errors;

  logic [DW-1:0] cmask, cval;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  typedef struct {
    int            img;
    int            nb;
    int            np;
    bit            toggle;
    logic [DW-1:0] cmask;
    logic [DW-1:0] cval;
    int            e_beats;
    int            e_pkts;
    int            e_err;
  } vec_t;

  beat_t         exp_q [$];
  logic [DW-1:0] img_d [DEPTH];
  logic [KW-1:0] img_k [DEPTH];
  logic          img_l [DEPTH];
  logic [DW-1:0] a_d   [5];
  vec_t          vecs  [7];

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  bit stall_q = 1'b0;
  logic [DW-1:0] hold_d;
  logic [KW:0]   hold_kl;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  // Loopback: returned stream mirrors the replay, optionally overwriting bytes on tlast beats.
  assign s_tvalid = m_tvalid & m_tready;
  assign s_tdata  = m_tlast ? ((m_tdata & ~cmask) | (cval & cmask)) : m_tdata;
  assign s_tkeep  = m_tkeep;
  assign s_tlast  = m_tlast;

  axis_pkt_player #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .ld_en         (ld_en),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .ld_keep       (ld_keep),
    .ld_last       (ld_last),
    .start         (start),
    .num_beats     (num_beats),
    .num_passes    (num_passes),
    .busy          (busy),
    .done          (done),
    .M_AXIS_tdata  (m_tdata),
    .M_AXIS_tkeep  (m_tkeep),
    .M_AXIS_tlast  (m_tlast),
    .M_AXIS_tvalid (m_tvalid),
    .M_AXIS_tready (m_tready),
    .S_AXIS_tdata  (s_tdata),
    .S_AXIS_tkeep  (s_tkeep),
    .S_AXIS_tlast  (s_tlast),
    .S_AXIS_tvalid (s_tvalid),
    .S_AXIS_tready (s_tready),
    .chk_beats     (chk_beats),
    .chk_pkts      (chk_pkts),
    .chk_errors    (chk_errors)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard: compare every M_AXIS handshake, hold stability under stall and done timing.
  always @(negedge aclk) begin
    beat_t e;
    if (areset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", 64'(m_tvalid), 64'd1);
        chk("hold_data", m_tdata, hold_d);
        chk("hold_keep_last", 64'({m_tkeep, m_tlast}), 64'(hold_kl));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_beat: got data %0h with no beat expected", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_tdata, e.d);
          chk("beat_keep_last", 64'({m_tkeep, m_tlast}), 64'({e.k, e.l}));
          last_hs_cyc = cyc;
        end
      end
      stall_q = m_tvalid && !m_tready;
      hold_d  = m_tdata;
      hold_kl = {m_tkeep, m_tlast};
      if (done) begin
        done_cnt++;
        chk("done_timing", 64'(cyc), 64'(last_hs_cyc + 1));
      end
    end
  end

  task automatic load_img(input int id);
    int n;
    n = (id == 0) ? 5 : DEPTH;
    for (int i = 0; i < n; i++) begin
      if (id == 0) begin
        img_d[i] = a_d[i];
        img_k[i] = (i == 4) ? 8'h0f : 8'hff;
        img_l[i] = (i == 4);
      end else begin
        img_d[i] = {32'hc0de0000 | 32'(i), 32'(i * 7 + 1)};
        img_k[i] = (i == 31) ? 8'h3f : 8'hff;
        img_l[i] = (i == 7);
      end
      ld_en   = 1'b1;
      ld_addr = AW'(i);
      ld_data = img_d[i];
      ld_keep = img_k[i];
      ld_last = img_l[i];
      tick();
    end
    ld_en = 1'b0;
  endtask

  task automatic push_exp(input int nb, input int np);
    beat_t e;
    int    passes;
    passes = (np == 0) ? 1 : np;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < nb; i++) begin
        e.d = img_d[i];
        e.k = img_k[i];
        e.l = img_l[i] | (i == nb - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic do_start(input int nb, input int np);
    start      = 1'b1;
    num_beats  = (AW+1)'(nb);
    num_passes = CW'(np);
    tick();
    start = 1'b0;
    chk("first_valid", 64'(m_tvalid), 64'd1);
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic finish_run(input int done0, input bit tog, input int eb, input int ep, input int ee);
    for (int c = 0; c < 3000 && done_cnt == done0; c++) begin
      if (tog) m_tready = ~m_tready;
      tick();
    end
    m_tready = 1'b1;
    chk("done_seen", 64'(done_cnt), 64'(done0 + 1));
    tick();
    tick();
    chk("done_once", 64'(done_cnt), 64'(done0 + 1));
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_valid", 64'(m_tvalid), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("chk_beats", 64'(chk_beats), 64'(eb));
    chk("chk_pkts", 64'(chk_pkts), 64'(ep));
    chk("chk_errors", 64'(chk_errors), 64'(ee));
  endtask

  task automatic run_vec(input vec_t v, input bit do_load);
    int done0;
    if (do_load) load_img(v.img);
    cmask    = v.cmask;
    cval     = v.cval;
    m_tready = 1'b1;
    push_exp(v.nb, v.np);
    done0 = done_cnt;
    do_start(v.nb, v.np);
    finish_run(done0, v.toggle, v.e_beats, v.e_pkts, v.e_err);
  endtask

  initial begin
    int done0;
    areset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_keep = '0; ld_last = 1'b0;
    start = 1'b0; num_beats = '0; num_passes = '0; m_tready = 1'b1;
    cmask = '0; cval = '0;
    a_d[0] = 64'hc40c02ca553e16fa;
    a_d[1] = 64'h0000007447c0887a;
    a_d[2] = 64'h0100000100030000;
    a_d[3] = 64'h0000000000000000;
    a_d[4] = 64'h5073930200000000;

    vecs[0] = '{img:0, nb:5,  np:1, toggle:1'b0, cmask:64'h0, cval:64'h0, e_beats:5,  e_pkts:1, e_err:0};
    vecs[1] = '{img:0, nb:5,  np:3, toggle:1'b1, cmask:64'h0, cval:64'h0, e_beats:15, e_pkts:3, e_err:0};
    vecs[2] = '{img:0, nb:5,  np:1, toggle:1'b0, cmask:64'hffffffff_00000000,
                cval:64'ha5a5a5a5_00000000, e_beats:5, e_pkts:1, e_err:0};
    vecs[3] = '{img:0, nb:5,  np:1, toggle:1'b0, cmask:64'h00000000_000000ff,
                cval:64'h00000000_0000005a, e_beats:5, e_pkts:1, e_err:1};
    vecs[4] = '{img:0, nb:4,  np:1, toggle:1'b0, cmask:64'h0, cval:64'h0, e_beats:4,  e_pkts:1, e_err:0};
    vecs[5] = '{img:0, nb:1,  np:0, toggle:1'b0, cmask:64'h0, cval:64'h0, e_beats:1,  e_pkts:1, e_err:0};
    vecs[6] = '{img:1, nb:32, np:2, toggle:1'b1, cmask:64'h0, cval:64'h0, e_beats:64, e_pkts:4, e_err:0};

    tick(); tick(); tick();
    chk("rst_valid", 64'(m_tvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_counters", 64'({chk_beats, chk_pkts, chk_errors}), 64'd0);
    areset = 1'b0;
    tick();
    chk("s_tready_after_rst", 64'(s_tready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], 1'b1);
    end

    // areset two cycles after start: everything clears, memory survives.
    load_img(0);
    cmask = '0;
    cval  = '0;
    push_exp(5, 3);
    do_start(5, 3);
    tick();
    areset = 1'b1;
    tick();
    chk("midrst_valid", 64'(m_tvalid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd0);
    chk("midrst_counters", 64'({chk_beats, chk_pkts, chk_errors}), 64'd0);
    areset = 1'b0;
    exp_q.delete();
    tick();
    chk("midrst_s_tready_back", 64'(s_tready), 64'd1);
    run_vec(vecs[0], 1'b0);

    // Rejected starts: num_beats of 0 and beyond DEPTH.
    start = 1'b1; num_beats = '0; num_passes = CW'(1);
    tick();
    start = 1'b0;
    chk("nb0_busy", 64'(busy), 64'd0);
    chk("nb0_valid", 64'(m_tvalid), 64'd0);
    chk("nb0_no_clear", 64'(chk_beats), 64'd5);
    start = 1'b1; num_beats = (AW+1)'(33);
    tick();
    start = 1'b0;
    chk("nb33_busy", 64'(busy), 64'd0);
    chk("nb33_no_clear", 64'(chk_beats), 64'd5);

    // ld_en while busy must not touch the image.
    push_exp(5, 1);
    m_tready = 1'b0;
    done0 = done_cnt;
    do_start(5, 1);
    ld_en = 1'b1; ld_addr = AW'(2); ld_data = 64'hdeadbeef_deadbeef; ld_keep = 8'h00; ld_last = 1'b1;
    tick();
    ld_en = 1'b0;
    chk("ld_busy_busy", 64'(busy), 64'd1);
    tick();
    m_tready = 1'b1;
    finish_run(done0, 1'b0, 5, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
